ps2_mouse_decoder: RTL and testbench

- Receives the raw PS/2 mouse stream (device-driven ps2_clk/ps2_data) and decodes standard 3-byte movement packets.
- Accumulates a clamped absolute cursor position and button state.
- Drives mouse_xpos/mouse_ypos/mouse_left into draw_rect_ctl, i.e. it is the producing end of that interface, in the clk65MHz domain.

---
 rtl/ps2_mouse_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
// Decodes standard 3-byte PS/2 mouse movement packets. The result is a clamped
// absolute cursor position plus the button state, driven into draw_rect_ctl
// in the clk65MHz domain.
//
// Ports:
//   clk65MHz     system clock (65 MHz)
//   rst          asynchronous, active-high reset
//   ps2_clk      PS/2 clock from the mouse (asynchronous)
//   ps2_data     PS/2 data from the mouse (asynchronous)
//   xpos         cursor x, 0..XMAX
//   ypos         cursor y, 0..YMAX, grows downward
//   mouse_left   left button state
//   mouse_right  right button state
//   new_event    one-cycle pulse when the outputs take a new packet
//   frame_err    one-cycle pulse on a parity or stop-bit error
//
// Frame FSM states:
//   state    | meaning
//   S_IDLE   | waiting for a start bit (sampled 0)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | checking odd parity over the data plus parity bit
//   S_STOP   | checking the stop bit (must be 1)
module ps2_mouse_decoder #(
    parameter int XMAX           = 1023,
    parameter int YMAX           = 767,
    parameter int TIMEOUT_CYCLES = 65000,
    parameter int FILTER_LEN     = 4
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        mouse_left,
    output logic        mouse_right,
    output logic        new_event,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [13:0] XMAX_S = 14'(XMAX);
    localparam logic signed [13:0] YMAX_S = 14'(YMAX);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_nx;
    logic [1:0]      clk_sync, data_sync;
    logic            clk_s, data_s;
    logic            clk_filt, clk_filt_d;
    logic [FW-1:0]   filt_cnt;
    logic            sample_edge;
    logic [TW-1:0]   tmo_cnt;
    logic            active, timeout;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [1:0]      byte_cnt;
    logic [7:0]      b0, b1;
    logic            byte_ok, bit_err;
    logic signed [13:0] dx, dy, x_sum, y_sum;
    logic [11:0]     x_next, y_next;

    assign clk_s       = clk_sync[1];
    assign data_s      = data_sync[1];
    assign sample_edge = clk_filt_d & ~clk_filt;

    // Synchronizers and glitch filter, all preset to the idle-bus level.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_filt_d <= clk_filt;
            // The level flips on the FILTER_LEN-th consecutive differing sample.
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // The timeout down-counter runs only while a frame or packet is open.
    // A sample edge always reloads it, so an edge wins over a coincident expiry.
    assign active  = (state != S_IDLE) || (byte_cnt != 2'd0);
    assign timeout = active && !sample_edge && (tmo_cnt == '0);

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            tmo_cnt <= TMO_LOAD;
        end else if (!active || sample_edge) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        byte_ok  = 1'b0;
        bit_err  = 1'b0;
        if (sample_edge) begin
            case (state)
                S_IDLE:   if (!data_s) state_nx = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
                S_PARITY: begin
                    if (^{shreg, data_s}) begin
                        state_nx = S_STOP;
                    end else begin
                        state_nx = S_IDLE;
                        bit_err  = 1'b1;
                    end
                end
                S_STOP: begin
                    state_nx = S_IDLE;
                    if (data_s) byte_ok = 1'b1;
                    else        bit_err = 1'b1;
                end
                default:  state_nx = S_IDLE;
            endcase
        end else if (timeout) begin
            state_nx = S_IDLE;
        end
    end

    // When the last byte completes, shreg holds the Y delta byte.
    always_comb begin
        dx     = b0[6] ? 14'sd0 : $signed({{6{b0[4]}}, b1});
        dy     = b0[7] ? 14'sd0 : $signed({{6{b0[5]}}, shreg});
        x_sum  = $signed({2'b00, xpos}) + dx;
        y_sum  = $signed({2'b00, ypos}) - dy;
        x_next = x_sum[11:0];
        y_next = y_sum[11:0];
        if (x_sum < 14'sd0)       x_next = 12'd0;
        else if (x_sum > XMAX_S)  x_next = 12'(XMAX);
        if (y_sum < 14'sd0)       y_next = 12'd0;
        else if (y_sum > YMAX_S)  y_next = 12'(YMAX);
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_cnt    <= '0;
            b0          <= '0;
            b1          <= '0;
            xpos        <= '0;
            ypos        <= '0;
            mouse_left  <= 1'b0;
            mouse_right <= 1'b0;
            new_event   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            new_event <= 1'b0;
            frame_err <= bit_err;
            if (sample_edge && state == S_IDLE) begin
                bit_cnt <= '0;
            end
            if (sample_edge && state == S_DATA) begin
                shreg   <= {data_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_err) begin
                byte_cnt <= '0;
            end else if (byte_ok) begin
                case (byte_cnt)
                    2'd0: begin
                        // bit3 is always set in a real header; anything else is
                        // treated as mid-packet data and skipped to resync.
                        if (shreg[3]) begin
                            b0       <= shreg;
                            byte_cnt <= 2'd1;
                        end
                    end
                    2'd1: begin
                        b1       <= shreg;
                        byte_cnt <= 2'd2;
                    end
                    default: begin
                        xpos        <= x_next;
                        ypos        <= y_next;
                        mouse_left  <= b0[0];
                        mouse_right <= b0[1];
                        new_event   <= 1'b1;
                        byte_cnt    <= 2'd0;
                    end
                endcase
            end else if (timeout) begin
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: bit-level PS/2 stimulus, with a cursor model
// written directly from the packet rules in plain integer arithmetic.
module tb_ps2_mouse_decoder;

    localparam int XMAX = 1023;
    localparam int YMAX = 767;
    localparam int TMO  = 4000;
    localparam int HALF = 10;

    logic        clk65MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] xpos, ypos;
    logic        mouse_left, mouse_right, new_event, frame_err;

    always #8 clk65MHz = ~clk65MHz;

    ps2_mouse_decoder #(
        .XMAX(XMAX), .YMAX(YMAX), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)
    ) dut (
        .clk65MHz   (clk65MHz),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .mouse_right(mouse_right),
        .new_event  (new_event),
        .frame_err  (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int ne_cycles = 0;
    int fe_cycles = 0;
    logic [11:0] snap_x = '0, snap_y = '0;
    logic        snap_l = 1'b0, snap_r = 1'b0;

    int m_x = 0, m_y = 0;
    bit m_l = 1'b0, m_r = 1'b0;

    // Every high cycle is counted, so a stretched pulse shows up as >1.
    // The snapshot captures the outputs during the pulse itself.
    always @(negedge clk65MHz) begin
        if (new_event === 1'b1) begin
            ne_cycles++;
            snap_x = xpos;
            snap_y = ypos;
            snap_l = mouse_left;
            snap_r = mouse_right;
        end
        if (frame_err === 1'b1) fe_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(input bit sgn, input bit ovf, input logic [7:0] lo);
        if (ovf) return 0;
        return sgn ? int'(lo) - 256 : int'(lo);
    endfunction

    task automatic model_apply(input logic [7:0] h, input logic [7:0] bx, input logic [7:0] by);
        m_x = clampi(m_x + delta(h[4], h[6], bx), XMAX);
        m_y = clampi(m_y - delta(h[5], h[7], by), YMAX);
        m_l = h[0];
        m_r = h[1];
    endtask

    // glitch_at selects a bit whose high phase gets a 2-cycle low pulse (-1: none).
    task automatic send_byte(input logic [7:0] b, input bit par_flip, input bit stop_bit,
                             input int glitch_at);
        logic [10:0] fr;
        fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            if (i == glitch_at) begin
                repeat (3) @(posedge clk65MHz);
                ps2_clk = 1'b0;
                repeat (2) @(posedge clk65MHz);
                ps2_clk = 1'b1;
                repeat (HALF - 5) @(posedge clk65MHz);
            end else begin
                repeat (HALF) @(posedge clk65MHz);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk65MHz);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk65MHz);
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] bx, input logic [7:0] by,
                            input string tag, input int glitch_at);
        int ne0;
        int fe0;
        ne0 = ne_cycles;
        fe0 = fe_cycles;
        send_byte(h, 1'b0, 1'b1, -1);
        send_byte(bx, 1'b0, 1'b1, glitch_at);
        send_byte(by, 1'b0, 1'b1, -1);
        model_apply(h, bx, by);
        repeat (4) @(posedge clk65MHz);
        @(negedge clk65MHz);
        chk({tag, "_ne_cycles"}, ne_cycles - ne0, 1);
        chk({tag, "_fe_cycles"}, fe_cycles - fe0, 0);
        chk({tag, "_x_at_event"}, snap_x, m_x);
        chk({tag, "_y_at_event"}, snap_y, m_y);
        chk({tag, "_left_at_event"}, snap_l, m_l);
        chk({tag, "_right_at_event"}, snap_r, m_r);
        chk({tag, "_x_hold"}, xpos, m_x);
        chk({tag, "_y_hold"}, ypos, m_y);
    endtask

    initial begin
        int ne0;
        int fe0;
        logic [7:0] rh, rx, ry;

        repeat (5) @(posedge clk65MHz);
        @(negedge clk65MHz);
        chk("reset_x", xpos, 0);
        chk("reset_y", ypos, 0);
        chk("reset_left", mouse_left, 0);
        chk("reset_right", mouse_right, 0);
        chk("reset_new_event", new_event, 0);
        chk("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk65MHz);

        send_pkt(8'h09, 8'h10, 8'h00, "move_click", -1);
        send_pkt(8'h28, 8'h00, 8'hF0, "y_down", -1);
        send_pkt(8'h08, 8'h00, 8'h20, "y_up_clamp", -1);
        send_pkt(8'h08, 8'hFF, 8'h00, "x_ramp1", -1);
        send_pkt(8'h08, 8'hFF, 8'h00, "x_ramp2", -1);
        send_pkt(8'h08, 8'hFF, 8'h00, "x_ramp3", -1);
        send_pkt(8'h08, 8'hEF, 8'h00, "x_to_1020", -1);
        send_pkt(8'h08, 8'h0A, 8'h00, "x_clamp_max", -1);
        send_pkt(8'h18, 8'h9C, 8'h00, "x_minus_100", -1);

        // Bad parity on byte 1.
        ne0 = ne_cycles;
        fe0 = fe_cycles;
        send_byte(8'h09, 1'b0, 1'b1, -1);
        send_byte(8'h10, 1'b1, 1'b1, -1);
        repeat (4) @(posedge clk65MHz);
        chk("parity_fe_cycles", fe_cycles - fe0, 1);
        chk("parity_ne_cycles", ne_cycles - ne0, 0);
        send_pkt(8'h0A, 8'h05, 8'h00, "after_parity", -1);

        // Bad stop bit on byte 1.
        ne0 = ne_cycles;
        fe0 = fe_cycles;
        send_byte(8'h09, 1'b0, 1'b1, -1);
        send_byte(8'h10, 1'b0, 1'b0, -1);
        repeat (4) @(posedge clk65MHz);
        chk("stop_fe_cycles", fe_cycles - fe0, 1);
        chk("stop_ne_cycles", ne_cycles - ne0, 0);

        // Header without bit3 is dropped; the next valid packet applies.
        ne0 = ne_cycles;
        send_byte(8'h00, 1'b0, 1'b1, -1);
        repeat (4) @(posedge clk65MHz);
        chk("resync_ne_cycles", ne_cycles - ne0, 0);
        send_pkt(8'h09, 8'h03, 8'h00, "resync", -1);
        send_pkt(8'h48, 8'hFF, 8'h00, "x_overflow", -1);

        // Two bytes, then silence past the timeout.
        ne0 = ne_cycles;
        fe0 = fe_cycles;
        send_byte(8'h09, 1'b0, 1'b1, -1);
        send_byte(8'h10, 1'b0, 1'b1, -1);
        repeat (TMO + 100) @(posedge clk65MHz);
        chk("timeout_ne_cycles", ne_cycles - ne0, 0);
        chk("timeout_fe_cycles", fe_cycles - fe0, 0);
        send_pkt(8'h08, 8'h04, 8'h00, "after_timeout", -1);

        send_pkt(8'h09, 8'h07, 8'h00, "glitch", 4);

        // Reset in the middle of a frame.
        ne0 = ne_cycles;
        fe0 = fe_cycles;
        send_byte(8'h09, 1'b0, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            repeat (HALF) @(posedge clk65MHz);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk65MHz);
            ps2_clk = 1'b1;
        end
        @(negedge clk65MHz);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk65MHz);
        chk("midrst_x", xpos, 0);
        chk("midrst_y", ypos, 0);
        chk("midrst_left", mouse_left, 0);
        chk("midrst_right", mouse_right, 0);
        rst = 1'b0;
        m_x = 0; m_y = 0; m_l = 1'b0; m_r = 1'b0;
        repeat (10) @(posedge clk65MHz);
        chk("midrst_ne_cycles", ne_cycles - ne0, 0);
        chk("midrst_fe_cycles", fe_cycles - fe0, 0);
        send_pkt(8'h09, 8'h10, 8'h00, "after_midrst", -1);
        send_pkt(8'h18, 8'h80, 8'h00, "x_clamp_zero", -1);

        for (int k = 0; k < 8; k++) begin
            rh = 8'($urandom) | 8'h08;
            rx = 8'($urandom);
            ry = 8'($urandom);
            send_pkt(rh, rx, ry, $sformatf("rand%0d", k), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
